// File: rtl/pixel_cipher_engine.sv
// Pixel stream cipher: keystream FIFO, frame FSM, 1-cycle result register.
// Optional chaining stage (prev feedback) enabled by `define CIPHER_DIFFUSION_EN.
module pixel_cipher_engine #(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned KEY_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] key_in,
  input  logic                  key_done,
  output logic                  key_req,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] iv,
  input  logic [15:0]           frame_len,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  key_ovf
);

  localparam int unsigned PTR_W = (KEY_FIFO_DEPTH > 1) ? $clog2(KEY_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] key_mem [KEY_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      key_cnt, key_cnt_nx;
  logic                  fifo_full, fifo_empty, full_nx;
  logic                  push, pop, drop;
  logic                  req_pend, pend_nx;
  logic                  key_req_q, key_ovf_q;
  logic [15:0]           len_q, pix_cnt;
  logic [DATA_WIDTH-1:0] key_cur, result, data_q;
  logic                  out_valid_q;
  logic                  start_acc;

  assign start_acc  = start & (state == IDLE);
  assign fifo_full  = (key_cnt == CNT_W'(KEY_FIFO_DEPTH));
  assign fifo_empty = (key_cnt == '0);
  assign key_cur    = key_mem[rd_ptr];
  assign pix_ready  = (state == RUN) & ~fifo_empty & (~out_valid_q | out_ready);
  assign pop        = pix_valid & pix_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push       = key_done & (~fifo_full | pop);
  assign drop       = key_done & fifo_full & ~pop;
  assign key_cnt_nx = key_cnt + CNT_W'(push) - CNT_W'(pop);
  assign full_nx    = (key_cnt_nx == CNT_W'(KEY_FIFO_DEPTH));
  assign pend_nx    = (req_pend | key_req_q) & ~key_done;

  assign key_req    = key_req_q;
  assign key_ovf    = key_ovf_q;
  assign data_out   = data_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

`ifdef CIPHER_DIFFUSION_EN
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] prev_q, prev_nx;

  // Chained cipher: encrypt feeds back the ciphertext, decrypt the input word.
  always_comb begin
    result  = '0;
    prev_nx = prev_q;
    if (!mode_q) begin
      result  = (pix_in + key_cur) ^ prev_q;
      prev_nx = result;
    end else begin
      result  = (pix_in ^ prev_q) - key_cur;
      prev_nx = pix_in;
    end
  end

  // Chaining state: seeded from iv at frame start, advanced per accepted pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      prev_q <= '0;
    end else if (start_acc) begin
      mode_q <= mode;
      prev_q <= iv;
    end else if (pop) begin
      prev_q <= prev_nx;
    end
  end
`else
  logic cfg_unused;

  // Plain keystream XOR; mode and iv have no effect in this build.
  assign result     = pix_in ^ key_cur;
  assign cfg_unused = ^{mode, iv};
`endif

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (frame_len == 16'd0) ? DONE : RUN;
      RUN:     if (pop && ((pix_cnt + 16'd1) == len_q)) state_nx = DRAIN;
      DRAIN:   if (!out_valid_q || out_ready) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame length latch and accepted-pixel counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q   <= '0;
      pix_cnt <= '0;
    end else if (start_acc) begin
      len_q   <= frame_len;
      pix_cnt <= '0;
    end else if (pop) begin
      pix_cnt <= pix_cnt + 16'd1;
    end
  end

  // Keystream storage; contents need no reset since the count gates reads.
  always_ff @(posedge clk) begin
    if (push) key_mem[wr_ptr] <= key_in;
  end

  // Keystream FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      key_cnt   <= '0;
      key_ovf_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      key_cnt <= key_cnt_nx;
      if (drop) key_ovf_q <= 1'b1;
    end
  end

  // Key request: one-cycle pulse, then held off until the word arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_pend  <= 1'b0;
      key_req_q <= 1'b0;
    end else begin
      req_pend  <= pend_nx;
      key_req_q <= ~full_nx & ~pend_nx;
    end
  end

  // Output register: holds until accepted, reload allowed on the accept cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (pop) begin
      data_q      <= result;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_cipher_engine.sv
// Self-checking bench for pixel_cipher_engine: directed table, corner
// sequences and randomized frames against a queue-based reference model.
module tb_pixel_cipher_engine;

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 4;
  localparam int          MAXC  = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] key_in;
  logic          key_done;
  logic          key_req;
  logic          start;
  logic          mode;
  logic [DW-1:0] iv;
  logic [15:0]   frame_len;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          frame_done;
  logic          key_ovf;

  pixel_cipher_engine #(.DATA_WIDTH(DW), .KEY_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_done(key_done),
    .key_req(key_req), .start(start), .mode(mode), .iv(iv),
    .frame_len(frame_len), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
    .key_ovf(key_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          m;
    logic [DW-1:0] ivv, k0, k1, p0, p1, e0, e1;
  } vec_t;

  // Reference model state
  logic [DW-1:0] kq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pix_src[$];
  logic [DW-1:0] mdl_prev;
  logic          mdl_mode;
  bit            use_model = 1'b1;
  bit            last_pop;
  int            acc, fd_seen;
  int            n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_cipher(input logic [DW-1:0] p, input logic [DW-1:0] k);
    logic [DW-1:0] r;
`ifdef CIPHER_DIFFUSION_EN
    if (!mdl_mode) begin
      r = DW'((int'(p) + int'(k)) % (1 << DW)) ^ mdl_prev;
      mdl_prev = r;
    end else begin
      r = DW'((int'(p ^ mdl_prev) - int'(k) + (1 << DW)) % (1 << DW));
      mdl_prev = p;
    end
`else
    r = p ^ k;
`endif
    return r;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [DW-1:0] k;
    last_pop = 1'b0;
    @(negedge clk);
    if (!rst_n) begin
      kq.delete();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 32'(data_out), 32'hFFFF_FFFF);
        else check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (pix_valid && pix_ready) begin
        if (kq.size() == 0) check("pop_on_empty_fifo", 32'(pix_ready), 32'd0);
        else begin
          k = kq.pop_front();
          if (use_model) exp_q.push_back(model_cipher(pix_in, k));
        end
        last_pop = 1'b1;
        acc++;
      end
      if (key_done && kq.size() < DEPTH) kq.push_back(key_in);
      if (frame_done) begin
        fd_seen++;
        check("frame_done_before_drain", 32'(exp_q.size()), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    if (last_pop) pix_valid = 1'b0;
  endtask

  task automatic feed_key(input logic [DW-1:0] k);
    key_done = 1'b1;
    key_in   = k;
    tick();
    key_done = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_key_ovf", 32'(key_ovf), 32'd0);
    check("rst_key_req", 32'(key_req), 32'd0);
    rst_n     = 1'b1;
    pix_valid = 1'b0;
    key_done  = 1'b0;
    start     = 1'b0;
    tick();
    check("key_req_after_rst", 32'(key_req), 32'd1);
  endtask

  task automatic start_frame(input logic m, input logic [DW-1:0] ivv, input int len);
    for (int i = 0; i < 50 && busy !== 1'b0; i++) tick();
    check("idle_before_start", 32'(busy), 32'd0);
    start     = 1'b1;
    mode      = m;
    iv        = ivv;
    frame_len = 16'(len);
    mdl_mode  = m;
    mdl_prev  = ivv;
    acc       = 0;
    fd_seen   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_frame(input int len, input bit rand_keys);
    int cyc = 0;
    while ((acc < len || exp_q.size() != 0 || fd_seen == 0) && cyc < MAXC) begin
      if (!pix_valid && acc < len && ($urandom % 4) != 0) begin
        pix_valid = 1'b1;
        pix_in    = (pix_src.size() != 0) ? pix_src.pop_front() : DW'($urandom);
      end
      out_ready = (($urandom % 3) != 0);
      key_done  = rand_keys && (kq.size() < DEPTH) && (($urandom % 2) != 0);
      key_in    = DW'($urandom);
      tick();
      cyc++;
    end
    key_done  = 1'b0;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    check("frame_completes_in_budget", 32'(cyc < MAXC), 32'd1);
    tick();
    tick();
    check("frame_done_pulses", 32'(fd_seen), 32'd1);
    check("idle_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input logic m, input logic [DW-1:0] ivv, input int len, input bit rand_keys);
    start_frame(m, ivv, len);
    drive_frame(len, rand_keys);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
`ifdef CIPHER_DIFFUSION_EN
    tbl[0] = '{1'b0, 12'h000, 12'h123, 12'h0FF, 12'h0F0, 12'h001, 12'h213, 12'h313};
    tbl[1] = '{1'b1, 12'h000, 12'h123, 12'h0FF, 12'h213, 12'h313, 12'h0F0, 12'h001};
    tbl[2] = '{1'b0, 12'h0A5, 12'h002, 12'h000, 12'hFFF, 12'h000, 12'h0A4, 12'h0A4};
    tbl[3] = '{1'b1, 12'h0A5, 12'h002, 12'h000, 12'h0A4, 12'h0A4, 12'hFFF, 12'h000};
`else
    tbl[0] = '{1'b0, 12'h000, 12'h123, 12'h0FF, 12'h0F0, 12'h001, 12'h1D3, 12'h0FE};
    tbl[1] = '{1'b1, 12'h000, 12'h123, 12'h0FF, 12'h213, 12'h313, 12'h330, 12'h3EC};
    tbl[2] = '{1'b0, 12'h0A5, 12'h002, 12'h000, 12'hFFF, 12'h000, 12'hFFD, 12'h000};
    tbl[3] = '{1'b1, 12'h0A5, 12'h002, 12'h000, 12'h0A4, 12'h0A4, 12'h0A6, 12'h0A4};
`endif
    rst_n = 1'b0; key_in = '0; key_done = 1'b0; start = 1'b0; mode = 1'b0;
    iv = '0; frame_len = '0; pix_in = '0; pix_valid = 1'b0; out_ready = 1'b1;
    acc = 0; fd_seen = 0;

    reset_dut();

    // Directed two-pixel frames
    foreach (tbl[i]) begin
      feed_key(tbl[i].k0);
      feed_key(tbl[i].k1);
      pix_src.delete();
      pix_src.push_back(tbl[i].p0);
      pix_src.push_back(tbl[i].p1);
      exp_q.delete();
      exp_q.push_back(tbl[i].e0);
      exp_q.push_back(tbl[i].e1);
      use_model = 1'b0;
      run_frame(tbl[i].m, tbl[i].ivv, 2, 1'b0);
      use_model = 1'b1;
    end

    // Backpressure: output held while downstream stalls, second pixel waits
    feed_key(12'h111);
    feed_key(12'h222);
    start_frame(1'b0, 12'h055, 2);
    pix_valid = 1'b1;
    pix_in    = 12'h321;
    out_ready = 1'b0;
    tick();
    check("bp_first_accept", 32'(acc), 32'd1);
    pix_valid = 1'b1;
    pix_in    = 12'h654;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_pix_ready", 32'(pix_ready), 32'd0);
      check("bp_data_hold", 32'(data_out), 32'(exp_q[0]));
    end
    check("bp_no_extra_accept", 32'(acc), 32'd1);
    drive_frame(2, 1'b0);
    check("bp_both_accepted", 32'(acc), 32'd2);

    // Overflow: fifth strobe dropped, first four keys used in order
    reset_dut();
    for (int i = 0; i < 5; i++) feed_key(DW'(12'h100 + i * 12'h011));
    check("ovf_set", 32'(key_ovf), 32'd1);
    pix_src.delete();
    repeat (4) pix_src.push_back(12'h000);
    exp_q.delete();
`ifdef CIPHER_DIFFUSION_EN
    exp_q.push_back(12'h100); exp_q.push_back(12'h011);
    exp_q.push_back(12'h133); exp_q.push_back(12'h000);
`else
    exp_q.push_back(12'h100); exp_q.push_back(12'h111);
    exp_q.push_back(12'h122); exp_q.push_back(12'h133);
`endif
    use_model = 1'b0;
    run_frame(1'b0, 12'h000, 4, 1'b0);
    use_model = 1'b1;
    check("ovf_sticky", 32'(key_ovf), 32'd1);

    // Zero-length frame: DONE one cycle after start, nothing accepted
    feed_key(12'h0AA);
    pix_valid = 1'b1;
    pix_in    = 12'h777;
    start_frame(1'b0, 12'h000, 0);
    check("zero_len_frame_done", 32'(frame_done), 32'd1);
    check("zero_len_pix_ready", 32'(pix_ready), 32'd0);
    tick();
    check("zero_len_done_one_cycle", 32'(frame_done), 32'd0);
    check("zero_len_idle", 32'(busy), 32'd0);
    check("zero_len_no_accept", 32'(acc), 32'd0);
    pix_valid = 1'b0;

    // Reset mid-frame with a word held in the output register
    feed_key(12'h0BB);
    start_frame(1'b0, 12'h000, 5);
    pix_valid = 1'b1;
    pix_in    = 12'h123;
    out_ready = 1'b0;
    tick();
    tick();
    check("midrst_out_valid_before", 32'(out_valid), 32'd1);
    reset_dut();
    out_ready = 1'b1;

    // Simultaneous push and pop on a full FIFO
    for (int i = 1; i <= 4; i++) feed_key(DW'(12'h200 + i));
    start_frame(1'b0, 12'h000, 1);
    pix_valid = 1'b1;
    pix_in    = 12'h010;
    key_done  = 1'b1;
    key_in    = 12'h205;
    tick();
    key_done = 1'b0;
    check("full_push_pop_accept", 32'(acc), 32'd1);
    check("full_push_pop_no_ovf", 32'(key_ovf), 32'd0);
    drive_frame(1, 1'b0);
    run_frame(1'b1, 12'h3C3, 4, 1'b0);
    check("full_push_pop_keys_consumed", 32'(kq.size()), 32'd0);

    // Randomized frames with random keystream arrival and backpressure
    for (int f = 0; f < 20; f++) begin
      run_frame(1'($urandom % 2), DW'($urandom), int'($urandom_range(1, 12)), 1'b1);
    end
    check("ovf_never_random", 32'(key_ovf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_cipher_engine.md
PIXEL_CIPHER_ENGINE -- requirements
Module: pixel_cipher_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, pixel/key word width.
REQ-002 SHALL have parameter KEY_FIFO_DEPTH, default 4 (power of two, >=2), keystream buffer entries.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- key_in  in  DATA_WIDTH  keystream word from the upstream sequence generator.
- key_done  in  1  one-cycle strobe; key_in valid.
- key_req  out  1  request for the next keystream word.
- start  in  1  frame start strobe.
- mode  in  1  0 = encrypt, 1 = decrypt; latched on start.
- iv  in  DATA_WIDTH  chaining seed; latched on start.
- frame_len  in  16  pixels per frame; latched on start.
- pix_in  in  DATA_WIDTH  input pixel or cipher word.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  pix_in accepted when valid & ready.
- data_out  out  DATA_WIDTH  result word.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts when valid & ready.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- key_ovf  out  1  sticky: keystream word dropped on full FIFO.

Function
REQ-004 SHALL implement FSM with states IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on start with frame_len != 0.
- IDLE->DONE on start with frame_len == 0.
- RUN->DRAIN on acceptance of pixel number frame_len.
- DRAIN->DONE when the output register empties.
- DONE->IDLE after one cycle, with frame_done = 1 in DONE.
REQ-005 SHALL ignore start outside IDLE.
REQ-006 SHALL, on start, latch mode, iv and frame_len, clear the pixel counter, and set prev = iv.
REQ-007 SHALL keep key FIFO contents across frames; the FIFO clears only on reset.
REQ-008 SHALL push key_in into the FIFO on key_done when the FIFO is not full.
REQ-009 SHALL, on key_done with a full FIFO, drop the word and set key_ovf until reset.
REQ-010 SHALL drive key_req = 1 when the FIFO is not full and no request is outstanding.
REQ-011 SHALL treat a request as outstanding from the cycle key_req = 1 until key_done; key_req is independent of FSM state.
REQ-012 SHALL drive pix_ready = (state == RUN) & FIFO non-empty & (!out_valid | out_ready).
REQ-013 SHALL, on each pixel acceptance, pop one key k, increment the counter, and load the output register on the next edge (latency 1 cycle).
REQ-014 SHALL compute with diffusion (macro defined), all arithmetic mod 2^DATA_WIDTH:
- encrypt: data_out = (pix_in + k) XOR prev; prev <= data_out.
- decrypt: data_out = (pix_in XOR prev) - k; prev <= pix_in.
REQ-015 SHALL hold out_valid and data_out stable until out_ready; a simultaneous accept and reload in one cycle is allowed.
REQ-016 SHALL apply a simultaneous key_done push and pixel pop on the same edge without loss; this holds when the FIFO is full, and counts as full only if no pop occurs.

Reset
REQ-017 SHALL, on rst_n = 0 at a clk edge (including mid-frame), set:
- state = IDLE; FIFO empty; no request outstanding; counter = 0.
- prev = 0, data_out = 0, out_valid = 0, pix_ready = 0.
- key_req = 0 in the reset cycle, frame_done = 0, key_ovf = 0.

Configuration
REQ-018 SHALL compile the chaining stage only when CIPHER_DIFFUSION_EN is defined.
REQ-019 SHALL, without CIPHER_DIFFUSION_EN, compute data_out = pix_in XOR k for both modes and ignore iv and prev; all other behaviour is unchanged.

Verification
REQ-020 SHALL cover encrypt with diffusion (width 12): iv=0x000, keys 0x123, 0x0FF, pixels 0x0F0, 0x001, frame_len=2 -> data_out 0x213 then 0x313, then a frame_done pulse.
REQ-021 SHALL cover decrypt with diffusion: iv=0x000, keys 0x123, 0x0FF, inputs 0x213, 0x313 -> data_out 0x0F0 then 0x001.
REQ-022 SHALL cover wrap-around: iv=0x0A5, key 0x002, pixel 0xFFF encrypt -> 0x001 XOR 0x0A5 = 0x0A4.
REQ-023 SHALL cover backpressure: out_ready held 0 for 5 cycles with pix_valid = 1 -> data_out stable, pix_ready = 0 after the first accept, no pixel lost.
REQ-024 SHALL cover overflow: 5 key_done strobes with no pixels, DEPTH = 4 -> key_ovf = 1; the first 4 keys are used in order.
REQ-025 SHALL cover degenerate and interrupted frames:
- start with frame_len = 0 -> frame_done exactly 1 cycle later, no pixel accepted.
- rst_n pulsed mid-frame -> all outputs return to reset values.
